// File: rtl/ms_tick_counter_if.sv
// Control/status bundle for ms_tick_counter. The capture port pair exists only
// when MS_TICK_COUNTER_CAPTURE_EN is defined.
interface ms_tick_counter_if #(
  parameter int COUNTER_WIDTH = 10
);
  logic                     EN;
  logic                     UP;
  logic                     MODE;
  logic                     LOAD;
  logic [COUNTER_WIDTH-1:0] LOAD_VAL;
  logic                     OVF_CLR;
  logic [COUNTER_WIDTH-1:0] out;
  logic                     tick;
  logic                     tc;
  logic                     ovf;
`ifdef MS_TICK_COUNTER_CAPTURE_EN
  logic                     CAPTURE;
  logic [COUNTER_WIDTH-1:0] cap_out;

  modport master (
    output EN, UP, MODE, LOAD, LOAD_VAL, OVF_CLR, CAPTURE,
    input  out, tick, tc, ovf, cap_out
  );
  modport slave (
    input  EN, UP, MODE, LOAD, LOAD_VAL, OVF_CLR, CAPTURE,
    output out, tick, tc, ovf, cap_out
  );
`else
  modport master (
    output EN, UP, MODE, LOAD, LOAD_VAL, OVF_CLR,
    input  out, tick, tc, ovf
  );
  modport slave (
    input  EN, UP, MODE, LOAD, LOAD_VAL, OVF_CLR,
    output out, tick, tc, ovf
  );
`endif
endinterface

// File: rtl/ms_tick_counter.sv
// Prescaled millisecond counter: modulus, up/down, load, wrap/saturate, sticky ovf.
// Optional count capture register enabled by MS_TICK_COUNTER_CAPTURE_EN.
module ms_tick_counter #(
  parameter int COUNTER_WIDTH = 10,
  parameter int PRESCALE      = 100000,
  parameter int MODULUS       = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  ms_tick_counter_if.slave  bus
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]            PS_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]            PS_ONE   = PW'(1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(MODULUS - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH:0]   MOD_EXT  = (COUNTER_WIDTH + 1)'(MODULUS);

  logic [PW-1:0]            ps_q;
  logic [COUNTER_WIDTH-1:0] cnt_q;
  logic [COUNTER_WIDTH-1:0] cnt_nxt;
  logic [COUNTER_WIDTH-1:0] load_cnt;
  logic                     tick_q;
  logic                     tc_q;
  logic                     ovf_q;
  logic                     ps_done;
  logic                     at_bound;
  logic                     hit;

  assign ps_done  = bus.EN && (ps_q == PS_LAST);
  assign at_bound = bus.UP ? (cnt_q == CNT_LAST) : (cnt_q == '0);
  assign hit      = ps_done && at_bound && !bus.LOAD;

  // Extra MSB keeps the clamp compare correct when MODULUS == 2^COUNTER_WIDTH.
  assign load_cnt = ({1'b0, bus.LOAD_VAL} >= MOD_EXT) ? CNT_LAST : bus.LOAD_VAL;

  always_comb begin
    cnt_nxt = cnt_q;
    if (bus.UP) begin
      if (at_bound) cnt_nxt = bus.MODE ? CNT_LAST : '0;
      else          cnt_nxt = cnt_q + CNT_ONE;
    end else begin
      if (at_bound) cnt_nxt = bus.MODE ? '0 : CNT_LAST;
      else          cnt_nxt = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ps_q   <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else if (bus.LOAD) begin
      // A coincident prescaler terminal is dropped; the period restarts here.
      ps_q   <= '0;
      cnt_q  <= load_cnt;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      tick_q <= ps_done;
      tc_q   <= ps_done && at_bound;
      if (bus.EN) ps_q <= ps_done ? '0 : ps_q + PS_ONE;
      if (ps_done) cnt_q <= cnt_nxt;
    end
  end

  // Set beats clear; a LOAD cycle leaves the flag alone.
  always_ff @(posedge CLK) begin
    if (RST)                         ovf_q <= 1'b0;
    else if (hit)                    ovf_q <= 1'b1;
    else if (!bus.LOAD && bus.OVF_CLR) ovf_q <= 1'b0;
  end

  assign bus.out  = cnt_q;
  assign bus.tick = tick_q;
  assign bus.tc   = tc_q;
  assign bus.ovf  = ovf_q;

`ifdef MS_TICK_COUNTER_CAPTURE_EN
  logic [COUNTER_WIDTH-1:0] cap_q;

  // Samples the registered count, i.e. the value before any same-edge update.
  always_ff @(posedge CLK) begin
    if (RST)              cap_q <= '0;
    else if (bus.CAPTURE) cap_q <= cnt_q;
  end

  assign bus.cap_out = cap_q;
`endif

endmodule

// File: tb/tb_ms_tick_counter.sv
// Bench for ms_tick_counter: fixed vector table, directed corner sequences,
// then random traffic checked against an arithmetic reference model.
module tb_ms_tick_counter;
  localparam int W = 4;
  localparam int P = 4;
  localparam int M = 10;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  ms_tick_counter_if #(.COUNTER_WIDTH(W)) bus();

  ms_tick_counter #(.COUNTER_WIDTH(W), .PRESCALE(P), .MODULUS(M)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_out, m_en, m_cap;
  bit m_tick, m_tc, m_ovf;

  typedef struct {
    bit rst, en, up, mode, load, clr;
    int lval;
    int e_out;
    bit e_tick, e_tc, e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit en, bit up, bit mode, bit load, bit clr,
                             int lval, int eo, bit et, bit ec, bit eov);
    vec_t r;
    r.rst = rst; r.en = en; r.up = up; r.mode = mode; r.load = load; r.clr = clr;
    r.lval = lval; r.e_out = eo; r.e_tick = et; r.e_tc = ec; r.e_ovf = eov;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit en, input bit up, input bit mode,
                       input bit load, input bit clr, input int lval);
    RST = rst; bus.EN = en; bus.UP = up; bus.MODE = mode;
    bus.LOAD = load; bus.OVF_CLR = clr; bus.LOAD_VAL = W'(lval);
  endtask

  // Next state computed from the behavioural rules using the inputs about to be sampled.
  task automatic model_step();
    bit fire, hit;
    fire = 0; hit = 0;
    if (RST) begin
      m_out = 0; m_en = 0; m_tick = 0; m_tc = 0; m_ovf = 0; m_cap = 0;
    end else begin
`ifdef MS_TICK_COUNTER_CAPTURE_EN
      if (bus.CAPTURE) m_cap = m_out;
`endif
      if (bus.LOAD) begin
        m_out = (int'(bus.LOAD_VAL) >= M) ? M - 1 : int'(bus.LOAD_VAL);
        m_en = 0; m_tick = 0; m_tc = 0;
      end else begin
        if (bus.EN) begin
          m_en++;
          if (m_en == P) begin fire = 1; m_en = 0; end
        end
        if (fire) begin
          if (bus.UP) begin
            hit = (m_out == M - 1);
            m_out = bus.MODE ? ((m_out + 1 > M - 1) ? M - 1 : m_out + 1) : (m_out + 1) % M;
          end else begin
            hit = (m_out == 0);
            m_out = bus.MODE ? ((m_out == 0) ? 0 : m_out - 1) : (m_out + M - 1) % M;
          end
        end
        m_tick = fire; m_tc = hit;
        if (hit) m_ovf = 1;
        else if (bus.OVF_CLR) m_ovf = 0;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int period, nticks;
    bit up_r, mode_r;
    bus.EN = 0; bus.UP = 1; bus.MODE = 0; bus.LOAD = 0; bus.LOAD_VAL = '0; bus.OVF_CLR = 0;
`ifdef MS_TICK_COUNTER_CAPTURE_EN
    bus.CAPTURE = 0;
`endif

    // reset, first tick, reset mid-count, load, wrap, ovf clear and set-beats-clear
    tbl.push_back(v(1,1,1,0,0,0,0, 0,0,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0,1,1,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(v(0,1,1,0,0,0,0, 1,0,0,0));
    tbl.push_back(v(1,1,1,0,0,0,0, 0,0,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0,1,1,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(v(0,1,1,0,1,0,8, 8,0,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0,1,1,0,0,0,0, 8,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,0, 9,1,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0,1,1,0,0,0,0, 9,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,0, 0,1,1,1));
    tbl.push_back(v(0,1,1,0,0,0,0, 0,0,0,1));
    tbl.push_back(v(0,1,1,0,0,1,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,0,8, 8,0,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0,1,1,0,0,0,0, 8,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,0, 9,1,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0,1,1,0,0,0,0, 9,0,0,0));
    tbl.push_back(v(0,1,1,0,0,1,0, 0,1,1,1));
    tbl.push_back(v(0,1,1,0,0,0,0, 0,0,0,1));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].mode, tbl[i].load, tbl[i].clr, tbl[i].lval);
      step();
      chk($sformatf("tbl%0d.out", i),  bus.out,  tbl[i].e_out);
      chk($sformatf("tbl%0d.tick", i), bus.tick, tbl[i].e_tick);
      chk($sformatf("tbl%0d.tc", i),   bus.tc,   tbl[i].e_tc);
      chk($sformatf("tbl%0d.ovf", i),  bus.ovf,  tbl[i].e_ovf);
    end

    // down + saturate from 1, then switch to wrap
    drive(0,1,0,1,1,0,1); step(); chk("sat.load", bus.out, 1);
    drive(0,1,0,1,0,0,0); run(3); chk("sat.pre_tick", bus.tick, 0);
    step(); chk("sat.out0", bus.out, 0); chk("sat.tc0", bus.tc, 0); chk("sat.tick0", bus.tick, 1);
    for (int k = 0; k < 2; k++) begin
      run(4);
      chk($sformatf("sat.hold%0d", k), bus.out, 0);
      chk($sformatf("sat.tc%0d", k), bus.tc, 1);
    end
    drive(0,1,0,0,0,0,0); run(4); chk("sat.wrap_out", bus.out, 9); chk("sat.wrap_tc", bus.tc, 1);

    // EN low for 3 cycles stretches one period to 7
    drive(0,1,1,0,1,0,5); step();
    drive(0,1,1,0,0,0,0); period = 1; nticks = 0;
    run(2); period += 2;
    bus.EN = 0; run(3); period += 3;
    bus.EN = 1;
    for (int k = 0; k < 12; k++) begin
      step(); if (bus.tick) begin nticks++; break; end
      period++;
    end
    chk("gap.tick_seen", nticks, 1);
    chk("gap.period", period, 7);
    chk("gap.out", bus.out, 6);

    // clamped load coincident with prescaler terminal
    drive(0,1,1,0,1,0,3); step();
    drive(0,1,1,0,0,0,0); run(3);
    drive(0,1,1,0,1,0,12); step();
    chk("clamp.out", bus.out, 9); chk("clamp.tick", bus.tick, 0); chk("clamp.tc", bus.tc, 0);
    drive(0,1,1,0,0,0,0); run(3); chk("clamp.no_tick", bus.tick, 0);
    step(); chk("clamp.wrap_out", bus.out, 0); chk("clamp.wrap_tc", bus.tc, 1);

`ifdef MS_TICK_COUNTER_CAPTURE_EN
    drive(0,1,1,0,1,0,5); step();
    drive(0,1,1,0,0,0,0); run(3);
    bus.CAPTURE = 1; step(); bus.CAPTURE = 0;
    chk("cap.value", bus.cap_out, 5); chk("cap.out", bus.out, 6);
`endif

    // random traffic against the model
    up_r = 1; mode_r = 0;
    for (int k = 0; k < 3000; k++) begin
      bit ld;
      if ($urandom_range(0, 9) == 0) up_r = ~up_r;
      if ($urandom_range(0, 9) == 0) mode_r = ~mode_r;
      ld = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, up_r, mode_r, ld,
            !ld && ($urandom_range(0, 19) == 0), $urandom_range(0, 15));
`ifdef MS_TICK_COUNTER_CAPTURE_EN
      bus.CAPTURE = ($urandom_range(0, 7) == 0);
`endif
      step();
      chk("rnd.out",  bus.out,  m_out);
      chk("rnd.tick", bus.tick, m_tick);
      chk("rnd.tc",   bus.tc,   m_tc);
      chk("rnd.ovf",  bus.ovf,  m_ovf);
`ifdef MS_TICK_COUNTER_CAPTURE_EN
      chk("rnd.cap",  bus.cap_out, m_cap);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ms_tick_counter.md
# ms_tick_counter

Parametrised millisecond counter with an integrated prescaler, programmable modulus, up/down direction, synchronous load and wrap or saturate mode. It is the next generation of the free-running millisecond counter. It converts the system clock into a one-cycle millisecond tick and counts ticks within 0..MODULUS-1. The block feeds display and timestamp logic and provides terminal-count and overflow status to control FSMs.

## Interface
Parameters:
- COUNTER_WIDTH, 10, width of the count value and LOAD_VAL.
- PRESCALE, 100000, CLK cycles per tick; must be ≥2.
- MODULUS, 1000, count range 0..MODULUS-1; must be ≥2 and ≤2^COUNTER_WIDTH.

Ports:
- CLK  in  1  single system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  enables the prescaler. When low, the prescaler and count hold.
- UP  in  1  direction: 1 counts up, 0 counts down.
- MODE  in  1  0 = wrap at the boundary, 1 = saturate at the boundary.
- LOAD  in  1  synchronous load of LOAD_VAL.
- LOAD_VAL  in  COUNTER_WIDTH  load value.
- OVF_CLR  in  1  clears the sticky overflow flag.
- out  out  COUNTER_WIDTH  current count.
- tick  out  1  one-cycle pulse, registered, coincident with each count update.
- tc  out  1  one-cycle pulse, registered, on a boundary event (wrap or saturate hit).
- ovf  out  1  sticky flag, set on any boundary event.

## Operation
- Priority on each edge: RST > LOAD > tick update > hold.
- RST: out=0, prescaler=0, tick=0, tc=0, ovf=0.
- Prescaler:
  - counts 0..PRESCALE-1 while EN=1;
  - at PRESCALE-1 with EN=1 it returns to 0 and a tick update occurs;
  - holds its value while EN=0.
- LOAD:
  - out ← LOAD_VAL; if LOAD_VAL ≥ MODULUS, out ← MODULUS-1 (clamp);
  - prescaler ← 0;
  - tick=0 and tc=0 that cycle; a coincident prescaler terminal count is discarded;
  - ovf is unchanged.
- Tick update, UP=1:
  - out<MODULUS-1: out+1.
  - out=MODULUS-1: MODE=0 gives 0, MODE=1 holds MODULUS-1. tc=1 in both cases.
- Tick update, UP=0:
  - out>0: out-1.
  - out=0: MODE=0 gives MODULUS-1, MODE=1 holds 0. tc=1 in both cases.
- A saturated counter asserts tc on every tick while it stays at the boundary.
- ovf:
  - set when tc is asserted;
  - OVF_CLR clears it;
  - a set in the same cycle as OVF_CLR wins, so ovf stays 1.
- UP, MODE and LOAD_VAL are sampled only on the edge where they are used. Direction or mode changes take effect on the next update, with no glitch.
- Arithmetic is modulo 2^COUNTER_WIDTH internally. out never leaves 0..MODULUS-1.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- EN rising with prescaler=0 at edge k: the first tick and out update occur on edge k+PRESCALE. After that, ticks follow every PRESCALE cycles of EN=1.
- Cycles with EN=0 stretch the period by exactly their count; no ticks are lost or added.
- tick and tc are high for exactly one cycle, the same cycle in which out shows the new value.
- LOAD latency is 1 cycle: out=LOAD_VAL after the edge that samples LOAD. The next tick comes PRESCALE EN-cycles later.
- RST mid-count takes effect on the next edge regardless of EN or LOAD.

## Configuration
- MS_TICK_COUNTER_CAPTURE_EN defined:
  - adds input CAPTURE (1 bit) and output cap_out (COUNTER_WIDTH, reset 0);
  - on an edge with CAPTURE=1, cap_out ← the out value from before that edge, i.e. the pre-update value if a tick coincides;
  - cap_out holds otherwise;
  - RST clears cap_out; LOAD does not affect it.
- Undefined: the CAPTURE and cap_out ports and their logic are absent. All other behaviour is identical.

## Test plan
- RST while counting (PRESCALE=4, MODULUS=10, COUNTER_WIDTH=4, EN=1, UP=1) → next edge out=0, tick=0, tc=0, ovf=0. First tick comes 4 edges after RST is released, with out=1.
- UP=1, MODE=0, count past out=9 → out goes 9→0, tc=1 and tick=1 in the same single cycle, ovf=1 sticky. OVF_CLR and a simultaneous tc in one cycle → ovf stays 1.
- UP=0, MODE=1 from out=1 → out 1→0, then holds 0 on each later tick with tc=1 each time. Switch to MODE=0 → next tick out=9.
- EN toggled low for 3 cycles mid-period → tick period measures 4+3=7 cycles. out increments exactly once.
- LOAD_VAL=12 (≥MODULUS) with LOAD coincident with a prescaler terminal → out=9, tick=0, prescaler restarts. Next tick 4 cycles later → out=0 (MODE=0), tc=1.
- With MS_TICK_COUNTER_CAPTURE_EN: CAPTURE on the tick edge where out goes 5→6 → cap_out=5 and out=6. Without the macro, the bench compiles without CAPTURE and cap_out and all other checks pass.
